// File: rtl/game_round_timer_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : game_pkg
// Purpose  : Shared round states, level encodings and the per-level limit lookup.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        TIMEUP = 2'd3
    } round_state_t;

    localparam int          c_sec_w    = 6;
    localparam logic [1:0]  c_lvl_beg0 = 2'b00;
    localparam logic [1:0]  c_lvl_beg1 = 2'b01;
    localparam logic [1:0]  c_lvl_med  = 2'b10;
    localparam logic [1:0]  c_lvl_adv  = 2'b11;

    function automatic logic [c_sec_w-1:0] limit_of(input logic [1:0] level,
                                                     input int t_beg,
                                                     input int t_med,
                                                     input int t_adv);
        case (level)
            c_lvl_beg0, c_lvl_beg1: return c_sec_w'(t_beg);
            c_lvl_med:              return c_sec_w'(t_med);
            c_lvl_adv:              return c_sec_w'(t_adv);
            default:                return c_sec_w'(t_beg);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_round_timer_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : game_round_timer_ctrl_if
// Purpose  : Control/status bundle between game-control FSM, round timer and HUD.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface game_round_timer_ctrl_if;
    import game_pkg::*;

    logic                start;
    logic                pause;
    logic                abort;
    logic [1:0]          level;
    logic [c_sec_w-1:0]  sec_left;
    logic                running;
    logic                paused;
    logic                warn;
    logic                time_up;

    modport master (
        output start, pause, abort, level,
        input  sec_left, running, paused, warn, time_up
    );

    modport slave (
        input  start, pause, abort, level,
        output sec_left, running, paused, warn, time_up
    );

endinterface

`default_nettype wire

// File: rtl/game_round_timer_ctrl_sec_tick_gen.sv
//------------------------------------------------------------------------------
// Module   : sec_tick_gen
// Purpose  : Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sec_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign tick = en && (r_cnt == c_last);

    // Counter only advances while enabled, so a paused round keeps its partial second.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_round_timer_ctrl.sv
//------------------------------------------------------------------------------
// Module   : game_round_timer_ctrl
// Purpose  : Round countdown controller with level-based limit, pause and abort.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module game_round_timer_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int T_BEG    = 60,
    parameter int T_MED    = 45,
    parameter int T_ADV    = 30,
    parameter int WARN_SEC = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    game_round_timer_ctrl_if.slave bus
);

    round_state_t        r_state;
    logic [c_sec_w-1:0]  r_sec_left;
    logic [1:0]          r_lvl;
    logic                r_running;
    logic                r_paused;
    logic                r_warn;
    logic                r_time_up;

    round_state_t        w_next_state;
    logic [c_sec_w-1:0]  w_next_sec;
    logic [1:0]          w_next_lvl;
    logic                w_clr;
    logic                w_tick;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (r_state == RUN),
        .tick  (w_tick)
    );

    // Abort outranks everything; within RUN the tick is applied before pause is considered.
    always_comb begin
        w_next_state = r_state;
        w_next_sec   = r_sec_left;
        w_next_lvl   = r_lvl;
        w_clr        = 1'b0;
        if (bus.abort) begin
            w_next_state = IDLE;
            w_clr        = 1'b1;
        end else begin
            case (r_state)
                IDLE, TIMEUP: begin
                    if (bus.start) begin
                        w_next_state = RUN;
                        w_next_lvl   = bus.level;
                        w_next_sec   = limit_of(bus.level, T_BEG, T_MED, T_ADV);
                        w_clr        = 1'b1;
                    end else if (r_state == IDLE) begin
                        w_next_sec   = limit_of(bus.level, T_BEG, T_MED, T_ADV);
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        if (r_sec_left <= c_sec_w'(1)) begin
                            w_next_sec   = '0;
                            w_next_state = TIMEUP;
                        end else begin
                            w_next_sec   = r_sec_left - 1'b1;
                        end
                    end
                    if (bus.pause && (w_next_state == RUN)) begin
                        w_next_state = PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.pause) begin
                        w_next_state = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sec_left <= '0;
            r_lvl      <= c_lvl_beg0;
            r_running  <= 1'b0;
            r_paused   <= 1'b0;
            r_warn     <= 1'b0;
            r_time_up  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_sec_left <= w_next_sec;
            r_lvl      <= w_next_lvl;
            r_running  <= (w_next_state == RUN);
            r_paused   <= (w_next_state == PAUSE);
            r_warn     <= ((w_next_state == RUN) || (w_next_state == PAUSE)) &&
                          (w_next_sec != '0) && (w_next_sec <= c_sec_w'(WARN_SEC));
            r_time_up  <= (r_state == RUN) && (w_next_state == TIMEUP);
        end
    end

    assign bus.sec_left = r_sec_left;
    assign bus.running  = r_running;
    assign bus.paused   = r_paused;
    assign bus.warn     = r_warn;
    assign bus.time_up  = r_time_up;

endmodule

`default_nettype wire

// File: tb/tb_game_round_timer_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_game_round_timer_ctrl
// Purpose  : Vector table, directed corner sequences and random run against a model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_round_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int T_BEG    = 6;
    localparam int T_MED    = 5;
    localparam int T_ADV    = 3;
    localparam int WARN_SEC = 2;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_TIMEUP = 3;

    typedef struct {
        logic       st, pa, ab;
        logic [1:0] lv;
        int         sec;
        logic       run, pau, wrn, tu;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    int m_mode = M_IDLE, m_sec = 0, m_elapsed = 0, m_tu = 0;

    vec_t tbl [16];

    game_round_timer_ctrl_if bus ();

    game_round_timer_ctrl #(
        .TICK_DIV (TICK_DIV),
        .T_BEG    (T_BEG),
        .T_MED    (T_MED),
        .T_ADV    (T_ADV),
        .WARN_SEC (WARN_SEC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int lim(input logic [1:0] lv);
        return (lv == 2'b11) ? T_ADV : (lv == 2'b10) ? T_MED : T_BEG;
    endfunction

    function automatic vec_t mk(input logic st, pa, ab, input logic [1:0] lv,
                                input int sec, input logic run, pau, wrn, tu);
        vec_t v;
        v.st = st; v.pa = pa; v.ab = ab; v.lv = lv;
        v.sec = sec; v.run = run; v.pau = pau; v.wrn = wrn; v.tu = tu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Round rules applied once per clock edge: elapsed counts RUN cycles within a second.
    task automatic model_edge(input logic rs, st, pa, ab, input logic [1:0] lv);
        m_tu = 0;
        if (rs) begin
            m_mode = M_IDLE; m_sec = 0; m_elapsed = 0;
        end else if (ab) begin
            m_mode = M_IDLE; m_elapsed = 0;
        end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == TICK_DIV) begin
                m_elapsed = 0;
                if (m_sec == 1) begin
                    m_sec = 0; m_mode = M_TIMEUP; m_tu = 1;
                end else begin
                    m_sec = m_sec - 1;
                end
            end
            if (pa && m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
            if (pa) m_mode = M_RUN;
        end else if (st) begin
            m_mode = M_RUN; m_sec = lim(lv); m_elapsed = 0;
        end else if (m_mode == M_IDLE) begin
            m_sec = lim(lv);
        end
    endtask

    task automatic step(input logic rs, st, pa, ab, input logic [1:0] lv);
        reset = rs; bus.start = st; bus.pause = pa; bus.abort = ab; bus.level = lv;
        @(posedge clk);
        model_edge(rs, st, pa, ab, lv);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        int w;
        w = ((m_mode == M_RUN || m_mode == M_PAUSE) && m_sec != 0 && m_sec <= WARN_SEC) ? 1 : 0;
        chk({tag, "_sec"},     32'(bus.sec_left), 32'(m_sec));
        chk({tag, "_running"}, 32'(bus.running),  32'(m_mode == M_RUN));
        chk({tag, "_paused"},  32'(bus.paused),   32'(m_mode == M_PAUSE));
        chk({tag, "_warn"},    32'(bus.warn),     32'(w));
        chk({tag, "_time_up"}, 32'(bus.time_up),  32'(m_tu));
    endtask

    task automatic run_n(input int n, input logic [1:0] lv, input string tag);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0, lv);
            check_model(tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Scenario: level 11 full countdown 3->0 after reset.
        tbl[0]  = mk(0, 0, 0, 2'b11, 3, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 2'b11, 3, 1, 0, 0, 0);
        for (int i = 2;  i <= 4;  i++) tbl[i] = mk(0, 0, 0, 2'b11, 3, 1, 0, 0, 0);
        for (int i = 5;  i <= 8;  i++) tbl[i] = mk(0, 0, 0, 2'b11, 2, 1, 0, 1, 0);
        for (int i = 9;  i <= 12; i++) tbl[i] = mk(0, 0, 0, 2'b11, 1, 1, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 2'b11, 0, 0, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 2'b11, 0, 0, 0, 0, 0);

        step(1, 0, 0, 0, 2'b11);
        step(1, 0, 0, 0, 2'b11);
        chk("reset_sec",     32'(bus.sec_left), 0);
        chk("reset_running", 32'(bus.running),  0);
        chk("reset_paused",  32'(bus.paused),   0);
        chk("reset_warn",    32'(bus.warn),     0);
        chk("reset_time_up", 32'(bus.time_up),  0);

        for (int i = 0; i < 16; i++) begin
            step(0, tbl[i].st, tbl[i].pa, tbl[i].ab, tbl[i].lv);
            chk($sformatf("vec%0d_sec", i),     32'(bus.sec_left), 32'(tbl[i].sec));
            chk($sformatf("vec%0d_running", i), 32'(bus.running),  32'(tbl[i].run));
            chk($sformatf("vec%0d_paused", i),  32'(bus.paused),   32'(tbl[i].pau));
            chk($sformatf("vec%0d_warn", i),    32'(bus.warn),     32'(tbl[i].wrn));
            chk($sformatf("vec%0d_time_up", i), 32'(bus.time_up),  32'(tbl[i].tu));
        end

        // Level change mid-run is ignored; then reset mid-RUN.
        step(0, 1, 0, 0, 2'b01);
        chk("lvl_start_sec", 32'(bus.sec_left), 6);
        run_n(4, 2'b11, "lvl_run");
        chk("lvl_after_tick_sec", 32'(bus.sec_left), 5);
        step(1, 0, 0, 0, 2'b11);
        chk("midreset_sec", 32'(bus.sec_left), 0);
        chk("midreset_run", 32'(bus.running), 0);
        chk("midreset_tu",  32'(bus.time_up), 0);
        step(0, 0, 0, 0, 2'b11);
        chk("postreset_preview", 32'(bus.sec_left), 3);
        step(0, 1, 0, 0, 2'b11);
        check_model("full_start");
        run_n(12, 2'b00, "full_run");
        chk("full_time_up", 32'(bus.time_up), 1);

        // Pause two cycles into a second, hold, resume: partial second preserved.
        step(0, 0, 0, 1, 2'b00);
        step(0, 1, 0, 0, 2'b00);
        run_n(1, 2'b00, "pz_run");
        step(0, 0, 1, 0, 2'b00);
        chk("pz_paused", 32'(bus.paused), 1);
        run_n(10, 2'b00, "pz_hold");
        chk("pz_hold_sec", 32'(bus.sec_left), 6);
        step(0, 0, 1, 0, 2'b00);
        chk("pz_resume_run", 32'(bus.running), 1);
        run_n(1, 2'b00, "pz_r1");
        chk("pz_r1_sec", 32'(bus.sec_left), 6);
        run_n(1, 2'b00, "pz_r2");
        chk("pz_r2_sec", 32'(bus.sec_left), 5);

        // Pause on the final 1->0 tick is dropped.
        step(0, 0, 0, 1, 2'b11);
        step(0, 1, 0, 0, 2'b11);
        run_n(11, 2'b11, "fin_run");
        step(0, 0, 1, 0, 2'b11);
        chk("fin_time_up", 32'(bus.time_up), 1);
        chk("fin_paused",  32'(bus.paused),  0);
        chk("fin_sec",     32'(bus.sec_left), 0);
        run_n(1, 2'b11, "fin_after");
        chk("fin_pulse_end", 32'(bus.time_up), 0);

        // Abort in PAUSE; start during RUN ignored.
        step(0, 1, 0, 0, 2'b10);
        chk("ab_start_sec", 32'(bus.sec_left), 5);
        run_n(1, 2'b10, "ab_run");
        step(0, 1, 0, 0, 2'b11);
        chk("ab_restart_ignored", 32'(bus.sec_left), 5);
        run_n(2, 2'b10, "ab_run2");
        chk("ab_sec4", 32'(bus.sec_left), 4);
        step(0, 0, 1, 0, 2'b10);
        chk("ab_paused", 32'(bus.paused), 1);
        step(0, 0, 0, 1, 2'b10);
        check_model("ab_abort");
        chk("ab_no_tu",  32'(bus.time_up), 0);
        chk("ab_idle_p", 32'(bus.paused),  0);
        run_n(1, 2'b10, "ab_preview");
        chk("ab_preview_sec", 32'(bus.sec_left), 5);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
                 2'($urandom_range(0, 3)));
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
